// File: rtl/fpu_issue_controller_if.sv
// Decode-side, FPU-side and writeback-side signals of the FPU issue controller.
// The controller takes the slave modport; the decode/pipeline side takes master.
interface fpu_issue_controller_if #(
    parameter int LAT_W = 4
);
    logic             dec_valid;
    logic             dec_fpu_dispatch;
    logic             dec_fpu_reg_write;
    logic             dec_variable;
    logic [LAT_W-1:0] dec_latency;
    logic [4:0]       dec_rd;
    logic [4:0]       dec_rs1;
    logic [4:0]       dec_rs2;
    logic [4:0]       dec_rs3;
    logic [2:0]       dec_rs_used;
    logic [2:0]       dec_rs_fp;
    logic             dec_rd_fp;
    logic             dec_rd_write;
    logic             flush;
    logic             fpu_done;
    logic             pipe_fp_we;
    logic             pipe_int_we;
    logic             stall_decode;
    logic             fpu_start;
    logic             fpu_busy;
    logic             wb_fp_we;
    logic             wb_int_we;
    logic [4:0]       wb_rd;

    modport master (
        output dec_valid, dec_fpu_dispatch, dec_fpu_reg_write, dec_variable,
               dec_latency, dec_rd, dec_rs1, dec_rs2, dec_rs3, dec_rs_used,
               dec_rs_fp, dec_rd_fp, dec_rd_write, flush, fpu_done,
               pipe_fp_we, pipe_int_we,
        input  stall_decode, fpu_start, fpu_busy, wb_fp_we, wb_int_we, wb_rd
    );

    modport slave (
        input  dec_valid, dec_fpu_dispatch, dec_fpu_reg_write, dec_variable,
               dec_latency, dec_rd, dec_rs1, dec_rs2, dec_rs3, dec_rs_used,
               dec_rs_fp, dec_rd_fp, dec_rd_write, flush, fpu_done,
               pipe_fp_we, pipe_int_we,
        output stall_decode, fpu_start, fpu_busy, wb_fp_we, wb_int_we, wb_rd
    );
endinterface

// File: rtl/fpu_issue_controller.sv
// Issues one op at a time to a non-pipelined multi-cycle FPU, stalls decode on
// structural/RAW/WAW hazards and arbitrates the FPU result onto a write port.
module fpu_issue_controller #(
    parameter int LAT_W = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    fpu_issue_controller_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY_FIX, BUSY_VAR, WB} state_t;

    state_t           state;
    state_t           state_next;
    logic [LAT_W-1:0] cnt;
    logic [LAT_W-1:0] cnt_next;
    logic [4:0]       pend_rd;
    logic             pend_fp;
    logic             pend_valid;
    logic [4:0]       wb_rd_q;

    logic raw1, raw2, raw3, waw, structural, hazard, dispatch;
    logic port_free;

    // Integer x0 never matches; FP f0 is a real register and does.
    assign raw1 = bus.dec_rs_used[0] & pend_valid & (bus.dec_rs_fp[0] == pend_fp)
                & (bus.dec_rs1 == pend_rd) & (bus.dec_rs_fp[0] | (bus.dec_rs1 != 5'd0));
    assign raw2 = bus.dec_rs_used[1] & pend_valid & (bus.dec_rs_fp[1] == pend_fp)
                & (bus.dec_rs2 == pend_rd) & (bus.dec_rs_fp[1] | (bus.dec_rs2 != 5'd0));
    assign raw3 = bus.dec_rs_used[2] & pend_valid & (bus.dec_rs_fp[2] == pend_fp)
                & (bus.dec_rs3 == pend_rd) & (bus.dec_rs_fp[2] | (bus.dec_rs3 != 5'd0));
    assign waw  = bus.dec_rd_write & pend_valid & (bus.dec_rd_fp == pend_fp)
                & (bus.dec_rd == pend_rd) & (bus.dec_rd_fp | (bus.dec_rd != 5'd0));
    assign structural = bus.dec_fpu_dispatch;
    assign hazard     = structural | raw1 | raw2 | raw3 | waw;

    assign bus.stall_decode = bus.dec_valid & (state != IDLE) & hazard;
    assign dispatch  = bus.dec_valid & bus.dec_fpu_dispatch & ~bus.stall_decode & ~bus.flush;
    assign bus.fpu_start = dispatch;
    assign bus.fpu_busy  = (state != IDLE);

    assign port_free     = pend_fp ? ~bus.pipe_fp_we : ~bus.pipe_int_we;
    assign bus.wb_fp_we  = (state == WB) & pend_valid & pend_fp & ~bus.pipe_fp_we;
    assign bus.wb_int_we = (state == WB) & pend_valid & ~pend_fp & ~bus.pipe_int_we;
    assign bus.wb_rd     = (state == WB) ? pend_rd : wb_rd_q;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (dispatch) begin
                    if (bus.dec_variable) begin
                        state_next = BUSY_VAR;
                    end else if (bus.dec_latency <= LAT_W'(1)) begin
                        state_next = WB;
                    end else begin
                        state_next = BUSY_FIX;
                        cnt_next   = bus.dec_latency - LAT_W'(2);
                    end
                end
            end
            BUSY_FIX: begin
                if (cnt == '0) begin
                    state_next = WB;
                end else begin
                    cnt_next = cnt - LAT_W'(1);
                end
            end
            BUSY_VAR: begin
                if (bus.fpu_done) begin
                    state_next = WB;
                end
            end
            WB: begin
                // A blocked port holds WB; the pipeline writeback always wins.
                if (!pend_valid || port_free) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            cnt     <= '0;
            wb_rd_q <= 5'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (state == WB) begin
                wb_rd_q <= pend_rd;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pend_rd    <= 5'd0;
            pend_fp    <= 1'b0;
            pend_valid <= 1'b0;
        end else if (dispatch) begin
            pend_rd    <= bus.dec_rd;
            pend_fp    <= bus.dec_fpu_reg_write;
            pend_valid <= bus.dec_fpu_reg_write | (bus.dec_rd != 5'd0);
        end
    end
endmodule

// File: doc/fpu_issue_controller.md
# fpu_issue_controller

Sequences the non-pipelined multi-cycle FPU behind the decode stage. It accepts one FPU dispatch at a time and tracks the single in-flight destination register. It stalls decode on structural, RAW and WAW hazards, and arbitrates the FPU result onto the FP or integer register-file write port against ordinary pipeline writebacks. It sits beside the control unit, consuming its `fpu_dispatch` / `fpu_reg_write` decode signals.

## Interface
- `LAT_W`, 4: width of the fixed-latency field; latencies 0..2^LAT_W-1.
- `clk` in 1: clock.
- `rstn` in 1: asynchronous active-low reset.
- `dec_valid` in 1: decode stage holds a valid instruction.
- `dec_fpu_dispatch` in 1: instruction is an FPU op.
- `dec_fpu_reg_write` in 1: result targets the FP file (0 = integer file).
- `dec_variable` in 1: op completes on `fpu_done`, not by counter.
- `dec_latency` in LAT_W: fixed latency L in cycles; 0 treated as 1.
- `dec_rd`, `dec_rs1`, `dec_rs2`, `dec_rs3` in 5 each: register indices.
- `dec_rs_used` in 3: bit i set means rs(i+1) is read.
- `dec_rs_fp` in 3: bit i set means rs(i+1) is an FP register.
- `dec_rd_fp` in 1: decode instruction's rd is FP (non-FPU writes too, e.g. flw).
- `dec_rd_write` in 1: decode instruction writes rd.
- `flush` in 1: squash the decode-stage instruction.
- `fpu_done` in 1: variable-latency op finished (pulse).
- `pipe_fp_we` in 1, `pipe_int_we` in 1: normal pipeline writeback is using the FP / integer write port this cycle.
- `stall_decode` out 1: hold fetch/decode.
- `fpu_start` out 1: one-cycle dispatch pulse to the FPU.
- `fpu_busy` out 1: an op is in flight (state != IDLE).
- `wb_fp_we` out 1, `wb_int_we` out 1: write the FPU result into the FP / integer file.
- `wb_rd` out 5: destination of the FPU result.

## Operation
- States: IDLE, BUSY_FIX, BUSY_VAR, WB. Registers: `cnt` (LAT_W), `pend_rd` (5), `pend_fp` (1), `pend_valid` (1).
- Dispatch condition, combinational: `dec_valid & dec_fpu_dispatch & ~stall_decode & ~flush`. `fpu_start` equals the dispatch condition.
- On dispatch:
  - Latch `pend_rd=dec_rd`, `pend_fp=dec_fpu_reg_write`, `pend_valid = dec_fpu_reg_write | (dec_rd!=0)`.
  - If `dec_variable`, go to BUSY_VAR.
  - Else if L<=1, go to WB.
  - Else go to BUSY_FIX with `cnt=L-2`.
- BUSY_FIX: if `cnt==0` go to WB, else decrement `cnt`.
- BUSY_VAR: go to WB the cycle after `fpu_done` is sampled high. `fpu_done` is ignored in IDLE, WB and the dispatch cycle.
- WB:
  - If `pend_valid` and the target port is free (`~pipe_fp_we` for FP, `~pipe_int_we` for integer), assert `wb_fp_we` or `wb_int_we` and go to IDLE.
  - If the port is busy, hold WB; the pipeline write always has priority.
  - If `~pend_valid` (integer rd=x0), no write; go to IDLE.
- `wb_rd = pend_rd` whenever in WB, else holds its last value.
- `stall_decode = dec_valid & (state!=IDLE) & (S | R | W)`:
  - S (structural) = `dec_fpu_dispatch`.
  - R (RAW) = any used rs(i) whose FP flag equals `pend_fp` and whose index equals `pend_rd`, gated by `pend_valid`.
  - W (WAW) = `dec_rd_write & (dec_rd_fp==pend_fp) & (dec_rd==pend_rd) & pend_valid`.
- Integer index 0 never matches for R or W. FP index 0 is a real register and does match.
- No dispatch is allowed in the WB cycle (covered by S).
- `flush` squashes only the decode instruction. An op already dispatched always completes and writes back.
- Reset mid-operation drops the in-flight op with no writeback.

## Timing
- Reset values: state=IDLE, `cnt=0`, `pend_*=0`, `wb_rd=0`. All outputs are 0.
- Dispatch at cycle T with fixed L>=1: WB entered, and the write lands, at T+max(L,1), if the port is free.
- Variable op: `fpu_done` high at cycle D gives WB at D+1.
- Each cycle the port is blocked extends WB (and the write) by one cycle.
- `stall_decode` and `fpu_start` are combinational from the decode inputs and the current state; there is no register delay.
- Back-to-back dispatch: the earliest next `fpu_start` is the cycle after the writeback cycle.

## Test plan
- Dispatch fadd at T=10 with L=3, `dec_rd=5` FP -> `fpu_start` at 10; `fpu_busy` 11–13; `wb_fp_we=1`, `wb_rd=5` at 13; IDLE at 14.
- L=0 and L=1 dispatch at T -> write at T+1. L=15 -> write at T+15.
- fdiv variable with `fpu_done` at cycle 40 -> `wb_fp_we` at 41. A `fpu_done` pulse in the dispatch cycle is ignored.
- In-flight FP rd=7; decode fmul reading f7 -> `stall_decode=1` until the WB write. Decode `add x7` (integer) -> no stall. Decode `flw f7` -> stall (WAW).
- `pipe_fp_we=1` for 2 cycles during WB -> WB held; write occurs in the 3rd cycle with `wb_rd` unchanged.
- `rstn` asserted during BUSY_FIX -> all outputs 0 immediately and no writeback. `flush` with dispatch conditions met -> no `fpu_start`.
